// File: rtl/fifo_pkg.sv
// Shared constants and pointer-compare helpers for the synchronous FIFO controller.
package fifo_pkg;

    localparam int unsigned MAX_PTR_W = 32;

    function automatic int unsigned ptr_width(input int unsigned d);
        return d + 1;
    endfunction

    function automatic int unsigned capacity(input int unsigned d);
        return 32'd1 << d;
    endfunction

    // Pointers carry one extra wrap bit above the d address bits.
    function automatic logic ptrs_empty(input logic [MAX_PTR_W-1:0] wp,
                                        input logic [MAX_PTR_W-1:0] rp);
        return wp == rp;
    endfunction

    function automatic logic ptrs_full(input logic [MAX_PTR_W-1:0] wp,
                                       input logic [MAX_PTR_W-1:0] rp,
                                       input int unsigned d);
        logic [MAX_PTR_W-1:0] diff;
        logic [MAX_PTR_W-1:0] mask;
        diff = wp ^ rp;
        mask = (32'd1 << d) - 32'd1;
        return ((diff & mask) == '0) && (((diff >> d) & 32'd1) != '0);
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping pointer counter with increment enable; wraps naturally at 2^width.
module fifo_ptr #(
    parameter int unsigned width = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             inc,
    output logic [width-1:0] ptr
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + width'(1);
        end
    end

endmodule

// File: rtl/fifo_ctrl_sync.sv
// Single-clock FIFO controller driving an external dual-port RAM, with registered status flags.
module fifo_ctrl_sync
    import fifo_pkg::*;
#(
    parameter int unsigned depth      = 8,
    parameter int unsigned almost_thr = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             wr_req,
    input  logic             rd_req,
    output logic             wr_en,
    output logic [depth-1:0] wr_address,
    output logic             rd_en,
    output logic [depth-1:0] rd_address,
    output logic             rd_valid,
    output logic [depth:0]   count,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic             overflow,
    output logic             underflow
);

    localparam int unsigned PW = ptr_width(depth);
    localparam logic [PW-1:0] AF_LEVEL = PW'(capacity(depth) - almost_thr);
    localparam logic [PW-1:0] AE_LEVEL = PW'(almost_thr);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr_next;
    logic [PW-1:0] rd_ptr_next;
    logic [PW-1:0] count_next;

    assign wr_en = reset_n & wr_req & ~full;
    assign rd_en = reset_n & rd_req & ~empty;

    fifo_ptr #(.width(PW)) u_wr_ptr (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (wr_en),
        .ptr     (wr_ptr)
    );

    fifo_ptr #(.width(PW)) u_rd_ptr (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (rd_en),
        .ptr     (rd_ptr)
    );

    assign wr_address = wr_ptr[depth-1:0];
    assign rd_address = rd_ptr[depth-1:0];

    // Flags look ahead to the post-edge pointers so they are exact the cycle after an access.
    assign wr_ptr_next = wr_ptr + {{depth{1'b0}}, wr_en};
    assign rd_ptr_next = rd_ptr + {{depth{1'b0}}, rd_en};
    assign count_next  = wr_ptr_next - rd_ptr_next;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            rd_valid     <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            count        <= count_next;
            full         <= ptrs_full(MAX_PTR_W'(wr_ptr_next), MAX_PTR_W'(rd_ptr_next), depth);
            empty        <= ptrs_empty(MAX_PTR_W'(wr_ptr_next), MAX_PTR_W'(rd_ptr_next));
            almost_full  <= count_next >= AF_LEVEL;
            almost_empty <= count_next <= AE_LEVEL;
            rd_valid     <= rd_en;
            overflow     <= wr_req & full;
            underflow    <= rd_req & empty;
        end
    end

endmodule

// File: tb/tb_fifo_ctrl_sync.sv
// Directed bench for fifo_ctrl_sync (depth=3, almost_thr=2) with an occupancy-level reference model.
module tb_fifo_ctrl_sync;

    localparam int DEPTH = 3;
    localparam int THR   = 2;
    localparam int CAP   = 1 << DEPTH;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             wr_req = 1'b0;
    logic             rd_req = 1'b0;
    logic             wr_en;
    logic [DEPTH-1:0] wr_address;
    logic             rd_en;
    logic [DEPTH-1:0] rd_address;
    logic             rd_valid;
    logic [DEPTH:0]   count;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic             overflow;
    logic             underflow;

    int vectors = 0;
    int miscompares = 0;

    fifo_ctrl_sync #(.depth(DEPTH), .almost_thr(THR)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .wr_req       (wr_req),
        .rd_req       (rd_req),
        .wr_en        (wr_en),
        .wr_address   (wr_address),
        .rd_en        (rd_en),
        .rd_address   (rd_address),
        .rd_valid     (rd_valid),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clock = ~clock;

    // Reference model: total writes/reads accepted and occupancy, nothing about pointer encoding.
    int m_writes = 0;
    int m_reads  = 0;
    int m_count  = 0;
    bit m_rvalid = 0;
    bit m_ovf    = 0;
    bit m_unf    = 0;
    bit acc_w;
    bit acc_r;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_writes = 0;
            m_reads  = 0;
            m_count  = 0;
            m_rvalid = 0;
            m_ovf    = 0;
            m_unf    = 0;
        end else begin
            acc_w    = wr_req && (m_count < CAP);
            acc_r    = rd_req && (m_count > 0);
            m_ovf    = wr_req && (m_count == CAP);
            m_unf    = rd_req && (m_count == 0);
            m_rvalid = acc_r;
            m_writes = m_writes + int'(acc_w);
            m_reads  = m_reads + int'(acc_r);
            m_count  = m_count + int'(acc_w) - int'(acc_r);
        end
    end

    task automatic check_output(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clock) begin
        check_output("wr_en",        int'(wr_en),        int'(reset_n && wr_req && m_count < CAP));
        check_output("rd_en",        int'(rd_en),        int'(reset_n && rd_req && m_count > 0));
        check_output("wr_address",   int'(wr_address),   m_writes % CAP);
        check_output("rd_address",   int'(rd_address),   m_reads % CAP);
        check_output("count",        int'(count),        m_count);
        check_output("full",         int'(full),         int'(m_count == CAP));
        check_output("empty",        int'(empty),        int'(m_count == 0));
        check_output("almost_full",  int'(almost_full),  int'(m_count >= CAP - THR));
        check_output("almost_empty", int'(almost_empty), int'(m_count <= THR));
        check_output("rd_valid",     int'(rd_valid),     int'(m_rvalid));
        check_output("overflow",     int'(overflow),     int'(m_ovf));
        check_output("underflow",    int'(underflow),    int'(m_unf));
    end

    // Hold the requests through one rising edge, then settle just after it.
    task automatic apply_stimulus(input bit wr, input bit rd, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            wr_req = wr;
            rd_req = rd;
            @(posedge clock);
            #1;
        end
        wr_req = 1'b0;
        rd_req = 1'b0;
    endtask

    initial begin
        $display("[TB] starting fifo_ctrl_sync bench");
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        #1;
        check_output("rst count", int'(count), 0);
        check_output("rst empty", int'(empty), 1);
        check_output("rst almost_empty", int'(almost_empty), 1);
        check_output("rst wr_address", int'(wr_address), 0);
        check_output("rst rd_address", int'(rd_address), 0);

        for (int i = 1; i <= CAP; i++) begin
            apply_stimulus(1'b1, 1'b0, 1);
            check_output("fill count", int'(count), i);
            check_output("fill almost_full", int'(almost_full), int'(i >= 6));
            check_output("fill full", int'(full), int'(i == 8));
        end
        wr_req = 1'b1;
        #1 check_output("ovf wr_en", int'(wr_en), 0);
        apply_stimulus(1'b1, 1'b0, 1);
        check_output("ovf pulse", int'(overflow), 1);
        check_output("ovf count", int'(count), 8);
        apply_stimulus(1'b0, 1'b0, 1);
        check_output("ovf clear", int'(overflow), 0);

        for (int i = 1; i <= CAP; i++) begin
            apply_stimulus(1'b0, 1'b1, 1);
            check_output("drain rd_valid", int'(rd_valid), 1);
            check_output("drain count", int'(count), 8 - i);
        end
        check_output("drain empty", int'(empty), 1);
        apply_stimulus(1'b0, 1'b1, 1);
        check_output("unf pulse", int'(underflow), 1);
        check_output("unf rd_valid", int'(rd_valid), 0);

        apply_stimulus(1'b1, 1'b1, 1);
        check_output("sim empty count", int'(count), 1);
        check_output("sim empty flag", int'(empty), 0);
        apply_stimulus(1'b1, 1'b0, 7);
        check_output("refill full", int'(full), 1);
        apply_stimulus(1'b1, 1'b1, 1);
        check_output("sim full count", int'(count), 7);
        check_output("sim full flag", int'(full), 0);

        apply_stimulus(1'b0, 1'b1, 4);
        check_output("pre-wrap count", int'(count), 3);
        apply_stimulus(1'b1, 1'b1, 20);
        check_output("wrap count", int'(count), 3);
        check_output("wrap almost_empty", int'(almost_empty), 0);
        check_output("wrap almost_full", int'(almost_full), 0);

        apply_stimulus(1'b1, 1'b0, 2);
        check_output("pre-reset count", int'(count), 5);
        wr_req = 1'b1;
        rd_req = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        check_output("arst count", int'(count), 0);
        check_output("arst empty", int'(empty), 1);
        check_output("arst wr_en", int'(wr_en), 0);
        check_output("arst rd_en", int'(rd_en), 0);
        check_output("arst wr_address", int'(wr_address), 0);
        @(posedge clock);
        #1 reset_n = 1'b1;
        rd_req = 1'b0;
        apply_stimulus(1'b1, 1'b0, 1);
        check_output("post-reset count", int'(count), 1);
        apply_stimulus(1'b0, 1'b0, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
